uart_frame_packer: RTL and testbench

//  Parametrised successor to the single-byte FFT UART framer. Pulls DATA_W-bit samples from an

---
 rtl/uart_frame_packer.sv | 173 +++++++++++++++++
 tb/tb_uart_frame_packer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_packer.sv
// Packs DATA_W-bit FIFO samples into UART frames: HDR0, HDR1, MSB-first payload bytes and an
// optional modulo-256 checksum, with an underrun timeout that aborts a starved frame.
module uart_frame_packer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FRAME_LEN  = 2048,
    parameter logic [7:0]  HDR0       = 8'h05,
    parameter logic [7:0]  HDR1       = 8'h64,
    parameter bit          CKSUM_EN   = 1'b1,
    parameter int unsigned UR_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    input  logic              uart_tx_done,
    output logic              uart_tx_en,
    output logic [7:0]        uart_tx_data,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned SW = $clog2(FRAME_LEN + 1);
    localparam int unsigned TW = (UR_TIMEOUT > 1) ? $clog2(UR_TIMEOUT) : 1;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT, S_RD, S_LATCH, S_UR_WAIT, S_DONE, S_ERR
    } state_e;

    typedef enum logic [1:0] {B_HDR0, B_HDR1, B_DATA, B_CKSUM} sel_e;

    state_e            state_q, state_d;
    sel_e              sel_q, sel_d;
    logic [BW-1:0]     byte_idx_q, byte_idx_d;
    logic [SW-1:0]     sample_cnt_q, sample_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        cksum_q, cksum_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              tx_en_q, tx_en_d;
    logic [DATA_W-1:0] shifted;
    logic              last_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sel_q        <= B_HDR0;
            byte_idx_q   <= '0;
            sample_cnt_q <= '0;
            shift_q      <= '0;
            tx_data_q    <= '0;
            cksum_q      <= '0;
            timer_q      <= '0;
            frame_cnt_q  <= '0;
            tx_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            byte_idx_q   <= byte_idx_d;
            sample_cnt_q <= sample_cnt_d;
            shift_q      <= shift_d;
            tx_data_q    <= tx_data_d;
            cksum_q      <= cksum_d;
            timer_q      <= timer_d;
            frame_cnt_q  <= frame_cnt_d;
            tx_en_q      <= tx_en_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        byte_idx_d   = byte_idx_q;
        sample_cnt_d = sample_cnt_q;
        shift_d      = shift_q;
        tx_data_d    = tx_data_q;
        cksum_d      = cksum_q;
        timer_d      = timer_q;
        frame_cnt_d  = frame_cnt_q;
        shifted      = shift_q << 8;
        // HDR1 hands over to the payload exactly like the last byte of a sample does
        last_byte    = (sel_q == B_HDR1) ||
                       ((sel_q == B_DATA) && (byte_idx_q == BW'(NB - 1)));
        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d      = S_SEND;
                    sel_d        = B_HDR0;
                    tx_data_d    = HDR0;
                    sample_cnt_d = '0;
                    byte_idx_d   = '0;
                    cksum_d      = '0;
                end
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (uart_tx_done) begin
                    if (sel_q == B_HDR0) begin
                        sel_d     = B_HDR1;
                        tx_data_d = HDR1;
                        state_d   = S_SEND;
                    end else if (sel_q == B_CKSUM) begin
                        state_d = S_DONE;
                    end else if (last_byte) begin
                        if (sample_cnt_q == SW'(FRAME_LEN)) begin
                            if (CKSUM_EN) begin
                                sel_d     = B_CKSUM;
                                tx_data_d = cksum_q;
                                state_d   = S_SEND;
                            end else begin
                                state_d = S_DONE;
                            end
                        end else if (!fifo_empty) begin
                            state_d = S_RD;
                        end else begin
                            state_d = S_UR_WAIT;
                            timer_d = '0;
                        end
                    end else begin
                        shift_d    = shifted;
                        tx_data_d  = shifted[DATA_W-1 -: 8];
                        cksum_d    = cksum_q + shifted[DATA_W-1 -: 8];
                        byte_idx_d = byte_idx_q + BW'(1);
                        state_d    = S_SEND;
                    end
                end
            end
            S_RD: state_d = S_LATCH;
            S_LATCH: begin
                shift_d      = fifo_rd_data;
                tx_data_d    = fifo_rd_data[DATA_W-1 -: 8];
                cksum_d      = cksum_q + fifo_rd_data[DATA_W-1 -: 8];
                byte_idx_d   = '0;
                sel_d        = B_DATA;
                sample_cnt_d = sample_cnt_q + SW'(1);
                state_d      = S_SEND;
            end
            S_UR_WAIT: begin
                if (!fifo_empty) begin
                    state_d = S_RD;
                end else if (timer_q == TW'(UR_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = S_IDLE;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_en_d    = (state_q == S_SEND);
        fifo_rd_en = (state_q == S_RD);
        frame_busy = (state_q != S_IDLE);
        frame_done = (state_q == S_DONE);
        frame_err  = (state_q == S_ERR);
    end

    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = tx_data_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Randomized bench for uart_frame_packer: FIFO and UART responders on the falling edge,
// expected byte stream built from the framing rules, directed underrun/enable/reset cases.
module tb_uart_frame_packer;
    localparam int DW = 16;
    localparam int NB = DW / 8;
    localparam int FL = 4;
    localparam int UR = 8;
    localparam logic [7:0] H0 = 8'h05;
    localparam logic [7:0] H1 = 8'h64;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          uart_tx_done;
    logic          uart_tx_en;
    logic [7:0]    uart_tx_data;
    logic          frame_busy;
    logic          frame_done;
    logic          frame_err;
    logic [15:0]   frame_cnt;

    uart_frame_packer #(
        .DATA_W(DW), .FRAME_LEN(FL), .HDR0(H0), .HDR1(H1), .CKSUM_EN(1'b1), .UR_TIMEOUT(UR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .uart_tx_done(uart_tx_done),
        .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .frame_busy(frame_busy),
        .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int mis_cnt = 0;

    logic [7:0]    exp_q[$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] plan_q[$];
    logic [DW-1:0] extra_q[$];

    int cyc = 0, done_seen = 0, err_seen = 0, done_pulses = 0, en_pulses = 0, rd_pulses = 0;
    int last_done_cyc = 0, last_err_cyc = 0, busy_cyc = 0, rd_cyc = 0, ucnt = 0;
    int exp_frames = 0;
    bit ub = 0, busy_prev = 0, hdr_pending = 0, rd_pending = 0;
    logic [7:0] cur_byte = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference stream: headers, first n planned samples MSB byte first, optional checksum
    task automatic expect_bytes(input int n, input bit with_ck);
        int sum;
        logic [DW-1:0] v;
        logic [7:0] b;
        sum = 0;
        exp_q.push_back(H0);
        exp_q.push_back(H1);
        for (int i = 0; i < n; i++) begin
            v = plan_q[i];
            for (int k = NB - 1; k >= 0; k--) begin
                b = 8'(v >> (8 * k));
                exp_q.push_back(b);
                sum += int'(b);
            end
        end
        if (with_ck) exp_q.push_back(8'(sum % 256));
    endtask

    task automatic push_plan(input int from, input int to);
        for (int i = from; i < to; i++) fifo_q.push_back(plan_q[i]);
    endtask

    task automatic random_plan();
        plan_q.delete();
        for (int i = 0; i < FL; i++) plan_q.push_back(DW'($urandom));
    endtask

    task automatic wait_end(input bit want_err, input int rd0, input int exp_rd);
        int d0, e0;
        bit hit;
        d0 = done_seen;
        e0 = err_seen;
        hit = 0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(posedge clk); #2;
            if (done_seen != d0 || err_seen != e0) hit = 1;
        end
        check("frame_end_timeout", 32'(hit), 32'd1);
        check("frame_err_pulse", err_seen - e0, 32'(want_err));
        check("frame_done_pulse", done_seen - d0, 32'(!want_err));
        if (!want_err) exp_frames++;
        @(posedge clk); #2;
        check("frame_cnt", 32'(frame_cnt), exp_frames);
        check("busy_after_frame", 32'(frame_busy), 32'd0);
        check("bytes_left", exp_q.size(), 32'd0);
        check("rd_pulses", rd_pulses - rd0, exp_rd);
    endtask

    task automatic wait_count(input string tag, input int which, input int target);
        bit hit;
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(posedge clk); #2;
            if ((which == 0 ? done_pulses : en_pulses) >= target) hit = 1;
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    // FIFO, UART and frame monitor all act on the falling edge, away from the DUT's edge
    initial begin
        uart_tx_done = 1'b0;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            uart_tx_done = 1'b0;
            if (!rst_n) begin
                ub = 0; busy_prev = 0; hdr_pending = 0; rd_pending = 0;
            end else begin
                if (frame_done) done_seen++;
                if (frame_err) begin
                    err_seen++;
                    last_err_cyc = cyc;
                end
                if (frame_done || frame_err)
                    check("done_err_exclusive", 32'(frame_done & frame_err), 32'd0);
                if (frame_busy && !busy_prev) begin
                    hdr_pending = 1;
                    busy_cyc = cyc;
                end
                busy_prev = frame_busy;
                if (ub) begin
                    check("tx_data_hold", 32'(uart_tx_data), 32'(cur_byte));
                    if (ucnt == 0) begin
                        uart_tx_done = 1'b1;
                        ub = 0;
                        done_pulses++;
                        last_done_cyc = cyc;
                    end else begin
                        ucnt--;
                    end
                end else if (!uart_tx_en && $urandom_range(0, 7) == 0) begin
                    uart_tx_done = 1'b1;
                end
                if (uart_tx_en) begin
                    en_pulses++;
                    if (exp_q.size() == 0) check("unexpected_tx", 32'd1, 32'd0);
                    else check("tx_byte", 32'(uart_tx_data), 32'(exp_q.pop_front()));
                    if (hdr_pending) check("hdr0_latency", cyc - busy_cyc, 32'd1);
                    if (rd_pending) check("rd_to_tx_latency", cyc - rd_cyc, 32'd3);
                    hdr_pending = 0;
                    rd_pending = 0;
                    cur_byte = uart_tx_data;
                    ub = 1;
                    ucnt = $urandom_range(0, 3);
                end
                if (fifo_rd_en) begin
                    rd_pulses++;
                    rd_pending = 1;
                    rd_cyc = cyc;
                    check("rd_en_while_empty", 32'(fifo_empty), 32'd0);
                    if (fifo_q.size() != 0) fifo_rd_data = fifo_q.pop_front();
                end
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    initial begin
        int rd0, d0, e0;
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx_en", 32'(uart_tx_en), 32'd0);
        check("rst_tx_data", 32'(uart_tx_data), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_busy", 32'(frame_busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // directed frame with boundary sample values
        plan_q = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};
        expect_bytes(FL, 1);
        push_plan(0, FL);
        rd0 = rd_pulses;
        enable = 1'b1;
        wait_end(0, rd0, FL);

        // random frames, alternating preloaded FIFO and trickled samples
        for (int f = 0; f < 6; f++) begin
            random_plan();
            expect_bytes(FL, 1);
            rd0 = rd_pulses;
            if (f % 2 == 0) begin
                push_plan(0, FL);
            end else begin
                push_plan(0, 1);
                for (int i = 1; i < FL; i++) begin
                    repeat ($urandom_range(0, 5)) @(posedge clk);
                    #2;
                    push_plan(i, i + 1);
                end
            end
            wait_end(0, rd0, FL);
        end

        // underrun: two samples only, abort after UR_TIMEOUT empty cycles
        random_plan();
        expect_bytes(2, 0);
        push_plan(0, 2);
        rd0 = rd_pulses;
        wait_end(1, rd0, 2);
        check("underrun_delay", last_err_cyc - last_done_cyc, 32'(UR + 1));

        // late sample arriving inside the timeout window completes normally
        random_plan();
        expect_bytes(FL, 1);
        push_plan(0, 2);
        rd0 = rd_pulses;
        d0 = done_pulses;
        wait_count("late_wait", 0, d0 + 2 + 2 * NB);
        repeat (5) @(posedge clk);
        #2;
        push_plan(2, FL);
        wait_end(0, rd0, FL);

        // enable dropped after HDR1: frame still completes, next one held off
        random_plan();
        expect_bytes(FL, 1);
        push_plan(0, FL);
        extra_q.delete();
        for (int i = 0; i < FL; i++) extra_q.push_back(DW'($urandom));
        for (int i = 0; i < FL; i++) fifo_q.push_back(extra_q[i]);
        rd0 = rd_pulses;
        d0 = done_pulses;
        wait_count("hdr1_wait", 0, d0 + 2);
        enable = 1'b0;
        wait_end(0, rd0, FL);
        e0 = en_pulses;
        repeat (20) @(posedge clk);
        #2;
        check("idle_while_disabled", 32'(frame_busy), 32'd0);
        check("no_tx_while_disabled", en_pulses - e0, 32'd0);
        check("fifo_untouched", fifo_q.size(), FL);
        plan_q = extra_q;
        expect_bytes(FL, 1);
        rd0 = rd_pulses;
        enable = 1'b1;
        wait_end(0, rd0, FL);

        // reset while the second payload byte is outstanding
        random_plan();
        expect_bytes(FL, 1);
        push_plan(0, FL);
        e0 = en_pulses;
        wait_count("mid_frame_wait", 1, e0 + 4);
        rst_n = 1'b0;
        #1;
        check("arst_tx_en", 32'(uart_tx_en), 32'd0);
        check("arst_tx_data", 32'(uart_tx_data), 32'd0);
        check("arst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("arst_busy", 32'(frame_busy), 32'd0);
        check("arst_done_err", 32'({frame_done, frame_err}), 32'd0);
        check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        exp_q.delete();
        fifo_q.delete();
        exp_frames = 0;
        d0 = done_seen;
        e0 = err_seen;
        repeat (2) @(posedge clk);
        #2;
        check("no_pulse_on_reset", (done_seen - d0) + (err_seen - e0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        random_plan();
        expect_bytes(FL, 1);
        push_plan(0, FL);
        rd0 = rd_pulses;
        wait_end(0, rd0, FL);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
